// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer
//   Quantises a stream of raw unsigned samples to 2-bit codes and packs
//   four of them (a,b,c,d) into one 8-bit frame for a 2-bit neuron stage.
//   in_last before the 4th sample aborts the frame.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_data     raw sample handshake
//   in_last                       early end-of-frame (abort unless 4th)
//   cfg_thr1..3                   quantisation thresholds
//   err_clr                       clears err_sticky
//   out_valid/out_ready/out_frame packed frame handshake
//                                 [1:0]=a [3:2]=b [5:4]=c [7:6]=d
//   frame_err                     one-cycle pulse per abort
//   err_sticky                    latched abort flag
//   frame_cnt                     frames delivered, wraps
module tnn_feature_packer #(
  parameter int DATA_W = 8,
  parameter int N_FEAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   cfg_thr1,
  input  logic [DATA_W-1:0]   cfg_thr2,
  input  logic [DATA_W-1:0]   cfg_thr3,
  input  logic                err_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*N_FEAT-1:0] out_frame,
  output logic                frame_err,
  output logic                err_sticky,
  output logic [15:0]         frame_cnt
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [N_FEAT-1:0][1:0]    coll_q, coll_d;
  logic [N_FEAT-1:0][1:0]    frame_now;
  logic [2*N_FEAT-1:0]       out_frame_q, out_frame_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      err_sticky_q, err_sticky_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  // Held low through reset so in_ready only rises on the first edge after release.
  logic                      rdy_q, rdy_d;

  logic [1:0] q;
  logic       accept, out_xfer, can_load, abort;

  // First matching rule wins, so non-monotonic thresholds need no special care.
  always_comb begin
    if (in_data < cfg_thr1)      q = 2'd0;
    else if (in_data < cfg_thr2) q = 2'd1;
    else if (in_data < cfg_thr3) q = 2'd2;
    else                         q = 2'd3;
  end

  assign in_ready = rdy_q && (state_q == COLLECT);
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  // Output register is free this edge: empty, or being drained right now.
  assign can_load = !out_valid_q || out_xfer;
  assign abort    = accept && in_last && (idx_q != 2'd3);

  always_comb begin
    frame_now           = coll_q;
    frame_now[idx_q]    = q;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    coll_d       = coll_q;
    out_frame_d  = out_frame_q;
    out_valid_d  = out_valid_q && !out_xfer;
    frame_err_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    frame_cnt_d  = frame_cnt_q + {15'd0, out_xfer};
    rdy_d        = 1'b1;

    case (state_q)
      COLLECT: begin
        if (abort) begin
          idx_d       = 2'd0;
          frame_err_d = 1'b1;
        end else if (accept) begin
          coll_d = frame_now;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (can_load) begin
              out_frame_d = frame_now;
              out_valid_d = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      FULL: begin
        // coll_q holds the complete pending frame here.
        if (can_load) begin
          out_frame_d = coll_q;
          out_valid_d = 1'b1;
          state_d     = COLLECT;
          idx_d       = 2'd0;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Set wins over clear.
    if (err_clr) err_sticky_d = 1'b0;
    if (abort)   err_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      idx_q        <= 2'd0;
      coll_q       <= '0;
      out_frame_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coll_q       <= coll_d;
      out_frame_q  <= out_frame_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      err_sticky_q <= err_sticky_d;
      frame_cnt_q  <= frame_cnt_d;
      rdy_q        <= rdy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_frame  = out_frame_q;
  assign frame_err  = frame_err_q;
  assign err_sticky = err_sticky_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tnn_feature_packer.sv
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, err_clr;
  logic [7:0]  in_data, cfg_thr1, cfg_thr2, cfg_thr3;
  logic        out_valid, out_ready, frame_err, err_sticky;
  logic [7:0]  out_frame;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  tnn_feature_packer #(.DATA_W(8), .N_FEAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cfg_thr1(cfg_thr1), .cfg_thr2(cfg_thr2), .cfg_thr3(cfg_thr3),
    .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
    .frame_err(frame_err), .err_sticky(err_sticky), .frame_cnt(frame_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]      exp_q[$];
  logic [1:0]      m_idx = 2'd0;
  logic [3:0][1:0] m_slots = '0;

  typedef struct {
    logic [7:0] s[4];
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] quant(input logic [7:0] x);
    if (x < cfg_thr1)      return 2'd0;
    else if (x < cfg_thr2) return 2'd1;
    else if (x < cfg_thr3) return 2'd2;
    else                   return 2'd3;
  endfunction

  task automatic model_accept(input logic [7:0] x, input logic last);
    if (last && m_idx != 2'd3) begin
      m_idx = 2'd0;
    end else begin
      m_slots[m_idx] = quant(x);
      if (m_idx == 2'd3) begin
        exp_q.push_back(m_slots);
        m_idx = 2'd0;
      end else m_idx = m_idx + 2'd1;
    end
  endtask

  // One clock: observe at negedge (scoreboard + accept), then step past posedge.
  task automatic tick(output logic acc);
    logic [7:0] e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_frame", {24'd0, out_frame}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_frame", {24'd0, out_frame}, {24'd0, e});
      end
    end
    if (acc) model_accept(in_data, in_last);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic send(input logic [7:0] x, input logic last);
    logic acc;
    int   n;
    in_valid = 1'b1; in_data = x; in_last = last;
    acc = 1'b0; n = 0;
    while (!acc && n < 64) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; err_clr = 1'b0;
    out_ready = 1'b0; cfg_thr1 = 8'd64; cfg_thr2 = 8'd128; cfg_thr3 = 8'd192;

    vecs[0] = '{s: '{8'd10, 8'd100, 8'd150, 8'd250}, exp: 8'hE4};
    vecs[1] = '{s: '{8'd63, 8'd64, 8'd191, 8'd192}, exp: 8'hE4};
    vecs[2] = '{s: '{8'hFF, 8'hFF, 8'hFF, 8'hFF},   exp: 8'hFF};
    vecs[3] = '{s: '{8'd0, 8'd0, 8'd0, 8'd0},       exp: 8'h00};
    vecs[4] = '{s: '{8'd200, 8'd63, 8'd130, 8'd64}, exp: 8'h63};
    vecs[5] = '{s: '{8'd127, 8'd191, 8'd63, 8'd192}, exp: 8'hC9};

    // Reset state
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_frame", {24'd0, out_frame}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    #12 rst_n = 1'b1;
    #1 chk("rdy_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", {31'd0, in_ready}, 32'd1);

    // Table vectors, streaming with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send4(vecs[i].s[0], vecs[i].s[1], vecs[i].s[2], vecs[i].s[3]);
      chk($sformatf("vec%0d_latency", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_frame", i), {24'd0, out_frame}, {24'd0, vecs[i].exp});
      idle(1);
      chk($sformatf("vec%0d_cnt", i), {16'd0, frame_cnt}, i + 1);
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back throughput: 8 samples in 8 consecutive cycles
    send4(8'd10, 8'd100, 8'd150, 8'd250);
    send4(8'd250, 8'd150, 8'd100, 8'd10);
    idle(1);
    chk("stream_cnt", {16'd0, frame_cnt}, 32'd8);

    // Backpressure: frame 1 held, frame 2 parks in FULL
    out_ready = 1'b0;
    send4(8'd10, 8'd100, 8'd150, 8'd250);
    send4(8'd255, 8'd0, 8'd200, 8'd130);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    idle(3);
    chk("bp_hold_frame", {24'd0, out_frame}, 32'hE4);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_frame2_loaded", {24'd0, out_frame}, 32'hB3);
    chk("bp_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    idle(2);
    out_ready = 1'b1;
    idle(1);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Abort on 2nd sample
    send(8'd10, 1'b0);
    send(8'd100, 1'b1);
    chk("abort_pulse", {31'd0, frame_err}, 32'd1);
    chk("abort_sticky", {31'd0, err_sticky}, 32'd1);
    idle(1);
    chk("abort_pulse_end", {31'd0, frame_err}, 32'd0);
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    send4(8'd250, 8'd150, 8'd100, 8'd10);
    chk("after_abort_frame", {24'd0, out_frame}, 32'h1B);
    idle(1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_clr", {31'd0, err_sticky}, 32'd0);

    // Abort coinciding with err_clr: set wins
    send(8'd5, 1'b0);
    err_clr = 1'b1;
    send(8'd6, 1'b1);
    err_clr = 1'b0;
    chk("clr_vs_abort", {31'd0, err_sticky}, 32'd1);

    // in_last on the 4th sample completes normally
    send(8'd70, 1'b0); send(8'd130, 1'b0); send(8'd200, 1'b0); send(8'd20, 1'b1);
    chk("last4_no_err", {31'd0, frame_err}, 32'd0);
    chk("last4_frame", {24'd0, out_frame}, 32'h39);
    idle(1);

    // frame_cnt wrap
    dut.frame_cnt_q = 16'hFFFE;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    idle(1);
    chk("cnt_ffff", {16'd0, frame_cnt}, 32'h0000_FFFF);
    send4(8'd1, 8'd70, 8'd3, 8'd4);
    idle(1);
    chk("cnt_wrap", {16'd0, frame_cnt}, 32'd0);

    // Reset mid-operation with a held frame and a partial one
    out_ready = 1'b0;
    send4(8'd10, 8'd100, 8'd150, 8'd250);
    send(8'd1, 1'b0); send(8'd2, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out_frame", {24'd0, out_frame}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("mrst_cnt", {16'd0, frame_cnt}, 32'd0);
    exp_q.delete();
    m_idx = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send4(8'd250, 8'd250, 8'd0, 8'd0);
    chk("mrst_new_frame", {24'd0, out_frame}, 32'h0F);
    idle(1);
    chk("mrst_cnt_after", {16'd0, frame_cnt}, 32'd1);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
